cmp_seq: RTL and testbench

- Multi-cycle wide-operand comparator.
- Compares two WORDS*LEN-bit operands by running one LEN-bit unsigned compare slice over the operand words, most-significant word (MSW) first.
- Terminates early on the first differing word.
- Produces the same five relations as the comb comparator (EQ/SG/UG/MG/XG) over the full width. Used where a full-width comb compare is too large; sits between an operand source and a result consumer via start/ready and valid/ack handshakes.

---
 rtl/cmp_seq.sv | 202 ++++++++++++++++++++
 tb/tb_cmp_seq.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cmp_seq.sv
// cmp_seq -- multi-cycle wide-operand comparator.
//
// Compares two W = LEN*WORDS bit operands one LEN-bit word per cycle. It
// starts at the most-significant word and stops at the first word that
// differs. From that one unsigned word compare and the two operand sign bits
// it derives the five full-width relations.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous reset, active high
//   start      compare request, accepted only while in_ready=1
//   in_ready   high while idle
//   A, B       W-bit operands, captured on accept
//   out_valid  result valid, held until out_ack
//   out_ack    consumer takes the result while out_valid=1
//   EQ         A == B
//   SG         signed(A)   > signed(B)
//   UG         unsigned(A) > unsigned(B)
//   MG         signed(A)   > unsigned(B), true numeric value
//   XG         unsigned(A) > signed(B),   true numeric value
//   cycles     number of words examined for the last result (1..WORDS)
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; operands captured on accept
// RUN   | one word compared per cycle, MSW first, early exit on difference
// DONE  | result registers valid and held until out_ack

module cmp_seq #(
   parameter  int LEN   = 16,
   parameter  int WORDS = 4,
   localparam int W     = LEN * WORDS,
   localparam int CW    = $clog2(WORDS + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          in_ready,
   input  logic [W-1:0]  A,
   input  logic [W-1:0]  B,
   output logic          out_valid,
   input  logic          out_ack,
   output logic          EQ,
   output logic          SG,
   output logic          UG,
   output logic          MG,
   output logic          XG,
   output logic [CW-1:0] cycles
);

   // A one-word operand still needs a 1-bit index register.
   localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_e;

   state_e          state_q,  state_d;
   logic [W-1:0]    a_q,      a_d;
   logic [W-1:0]    b_q,      b_d;
   logic [IW-1:0]   idx_q,    idx_d;
   logic [CW-1:0]   cnt_q,    cnt_d;
   logic            eq_q,     eq_d;
   logic            sg_q,     sg_d;
   logic            ug_q,     ug_d;
   logic            mg_q,     mg_d;
   logic            xg_q,     xg_d;
   logic [CW-1:0]   cycles_q, cycles_d;

   logic [LEN-1:0]  word_a;
   logic [LEN-1:0]  word_b;
   logic [CW-1:0]   cnt_inc;
   logic            fin;
   logic            eq_int;
   logic            ug_int;
   logic            sa;
   logic            sb;

   // The word mux uses constant part-selects, so only one LEN-bit slice is
   // ever compared.
   always_comb begin
      word_a = '0;
      word_b = '0;
      for (int i = 0; i < WORDS; i++) begin
         if (idx_q == IW'(i)) begin
            word_a = a_q[i*LEN +: LEN];
            word_b = b_q[i*LEN +: LEN];
         end
      end
   end

   assign sa      = a_q[W-1];
   assign sb      = b_q[W-1];
   assign cnt_inc = cnt_q + CW'(1);

   always_comb begin
      state_d  = state_q;
      a_d      = a_q;
      b_d      = b_q;
      idx_d    = idx_q;
      cnt_d    = cnt_q;
      eq_d     = eq_q;
      sg_d     = sg_q;
      ug_d     = ug_q;
      mg_d     = mg_q;
      xg_d     = xg_q;
      cycles_d = cycles_q;
      fin      = 1'b0;
      eq_int   = 1'b0;
      ug_int   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               a_d     = A;
               b_d     = B;
               idx_d   = IW'(WORDS - 1);
               cnt_d   = '0;
               state_d = S_RUN;
            end
         end

         S_RUN: begin
            cnt_d = cnt_inc;
            if (word_a != word_b) begin
               fin    = 1'b1;
               ug_int = (word_a > word_b);
            end else if (idx_q == '0) begin
               fin    = 1'b1;
               eq_int = 1'b1;
            end else begin
               idx_d = idx_q - IW'(1);
            end

            if (fin) begin
               state_d  = S_DONE;
               eq_d     = eq_int;
               ug_d     = ug_int;
               cycles_d = cnt_inc;
               // Operands of differing sign decide SG on the sign alone.
               // With equal operands ug_int is 0, so SG and MG fall to 0
               // and XG reduces to sb.
               sg_d     = (sa != sb) ? sb : ug_int;
               // A negative signed A can never exceed a non-negative B.
               mg_d     = sa ? 1'b0 : ug_int;
               // A negative signed B is exceeded by any unsigned A.
               xg_d     = sb ? 1'b1 : ug_int;
            end
         end

         S_DONE: begin
            if (out_ack) begin
               state_d = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         a_q      <= '0;
         b_q      <= '0;
         idx_q    <= '0;
         cnt_q    <= '0;
         eq_q     <= 1'b0;
         sg_q     <= 1'b0;
         ug_q     <= 1'b0;
         mg_q     <= 1'b0;
         xg_q     <= 1'b0;
         cycles_q <= '0;
      end else begin
         state_q  <= state_d;
         a_q      <= a_d;
         b_q      <= b_d;
         idx_q    <= idx_d;
         cnt_q    <= cnt_d;
         eq_q     <= eq_d;
         sg_q     <= sg_d;
         ug_q     <= ug_d;
         mg_q     <= mg_d;
         xg_q     <= xg_d;
         cycles_q <= cycles_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign out_valid = (state_q == S_DONE);
   assign EQ        = eq_q;
   assign SG        = sg_q;
   assign UG        = ug_q;
   assign MG        = mg_q;
   assign XG        = xg_q;
   assign cycles    = cycles_q;

endmodule

// File: tb/tb_cmp_seq.sv
// Testbench for cmp_seq: directed cases plus randomized operands checked
// against a full-width arithmetic reference model.

module tb_cmp_seq;

   localparam int LEN   = 16;
   localparam int WORDS = 4;
   localparam int W     = LEN * WORDS;
   localparam int CW    = $clog2(WORDS + 1);

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          in_ready;
   logic [W-1:0]  A;
   logic [W-1:0]  B;
   logic          out_valid;
   logic          out_ack;
   logic          EQ, SG, UG, MG, XG;
   logic [CW-1:0] cycles;

   int checks = 0;
   int errors = 0;

   cmp_seq #(.LEN(LEN), .WORDS(WORDS)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .in_ready  (in_ready),
      .A         (A),
      .B         (B),
      .out_valid (out_valid),
      .out_ack   (out_ack),
      .EQ        (EQ),
      .SG        (SG),
      .UG        (UG),
      .MG        (MG),
      .XG        (XG),
      .cycles    (cycles)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // Reference: relations from true numeric values, using W+1 bit signed
   // extensions for the mixed-sign compares; words examined from the MSW
   // down to the first difference.
   task automatic ref_model(input logic [W-1:0] a, input logic [W-1:0] b,
                            output logic [4:0] rel, output int k);
      logic signed [W:0] a_s, a_u, b_s, b_u;
      logic eq, sg, ug, mg, xg;
      a_s = {a[W-1], a};
      a_u = {1'b0, a};
      b_s = {b[W-1], b};
      b_u = {1'b0, b};
      eq  = (a == b);
      ug  = (a > b);
      sg  = ($signed(a) > $signed(b));
      mg  = (a_s > b_u);
      xg  = (a_u > b_s);
      rel = {eq, sg, ug, mg, xg};
      k = 0;
      for (int i = WORDS - 1; i >= 0; i--) begin
         k++;
         if (a[i*LEN +: LEN] != b[i*LEN +: LEN]) break;
      end
   endtask

   function automatic logic [W-1:0] rnd_w();
      return {$urandom, $urandom};
   endfunction

   // One full transaction. Latency is counted in cycles from the cycle in
   // which start is presented to the first cycle with out_valid high.
   task automatic do_cmp(input string tag, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int hold);
      logic [4:0] rel;
      int         k;
      int         c;
      ref_model(a, b, rel, k);
      check({tag, ":ready"}, 64'(in_ready), 64'd1);
      start = 1'b1;
      A     = a;
      B     = b;
      @(posedge clk); #1;
      start = 1'b0;
      A     = rnd_w();
      B     = rnd_w();
      c     = 2;
      while (!out_valid && c < WORDS + 10) begin
         start   = 1'($urandom_range(0, 1));
         out_ack = 1'($urandom_range(0, 1));
         A       = rnd_w();
         B       = rnd_w();
         @(posedge clk); #1;
         c++;
      end
      start   = 1'b0;
      out_ack = 1'b0;
      check({tag, ":latency"}, out_valid ? 64'(c - 1) : 64'd0, 64'(k + 1));
      check({tag, ":result"},
            64'({out_valid, in_ready, EQ, SG, UG, MG, XG, cycles}),
            64'({1'b1, 1'b0, rel, CW'(k)}));
      for (int h = 0; h < hold; h++) begin
         start = 1'($urandom_range(0, 1));
         A     = rnd_w();
         B     = rnd_w();
         @(posedge clk); #1;
         check({tag, ":hold"},
               64'({out_valid, in_ready, EQ, SG, UG, MG, XG, cycles}),
               64'({1'b1, 1'b0, rel, CW'(k)}));
      end
      start   = 1'b0;
      out_ack = 1'b1;
      @(posedge clk); #1;
      out_ack = 1'b0;
      check({tag, ":ack_idle"}, 64'({in_ready, out_valid}), 64'(2'b10));
   endtask

   initial begin
      logic [W-1:0] a, b;
      rst     = 1'b1;
      start   = 1'b0;
      out_ack = 1'b0;
      A       = '0;
      B       = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset_state",
            64'({in_ready, out_valid, EQ, SG, UG, MG, XG, cycles}),
            64'({1'b1, 1'b0, 5'b0, CW'(0)}));
      rst = 1'b0;

      do_cmp("eq_mixed", 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 0);
      do_cmp("msw_diff", 64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 0);
      do_cmp("lsw_diff", 64'h0000_0000_0000_0002, 64'h0000_0000_0000_0001, 0);
      do_cmp("neg_gt",   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 0);
      do_cmp("hold10",   64'h1234_0000_0000_0000, 64'h1233_FFFF_FFFF_FFFF, 10);
      do_cmp("eq_ones",  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 0);

      // Reset in the middle of RUN, after the top word matched.
      start = 1'b1;
      A     = 64'h0123_4567_89AB_CDEF;
      B     = 64'h0123_4567_89AB_CDEF;
      @(posedge clk); #1;
      start = 1'b0;
      @(posedge clk); #1;
      check("mid_run", 64'({in_ready, out_valid}), 64'(2'b00));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("rst_in_run",
            64'({in_ready, out_valid, EQ, SG, UG, MG, XG, cycles}),
            64'({1'b1, 1'b0, 5'b0, CW'(0)}));
      @(posedge clk); #1;
      check("rst_no_result", 64'({in_ready, out_valid}), 64'(2'b10));
      do_cmp("after_rst", 64'h0000_0001_0000_0000, 64'h8000_0000_0000_0000, 0);

      for (int n = 0; n < 200; n++) begin
         a = rnd_w();
         b = a;
         case ($urandom_range(0, 4))
            0: b = a;
            1: b = rnd_w();
            2: b[W-1] = ~b[W-1];
            default: begin
               int j;
               j = $urandom_range(0, WORDS - 1);
               b[j*LEN +: LEN] = LEN'($urandom);
            end
         endcase
         if ($urandom_range(0, 1) == 1) begin
            logic [W-1:0] t;
            t = a;
            a = b;
            b = t;
         end
         do_cmp("rand", a, b, $urandom_range(0, 3));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
